spi_prot_trig: RTL and testbench
================================

# spi_prot_trig

Parametrised SPI protocol trigger unit for the logic-analyzer digital core. It monitors the SS_n, SCLK and MOSI signals arriving on the CH1/CH2/CH3 protocol-mux inputs and reconstructs each frame. When a frame matches a programmable pattern it raises a single-cycle trigger pulse to the capture/trigger logic. Relative to the fixed 8/16-bit SPI source it replaces, it adds configurable frame length, bit masking, selectable sample edge and an Nth-match trigger count.

## Interface
- DATA_W, 16, maximum frame length in bits (≥2); sizes the shift, match and mask registers
- CNT_W, 4, width of the match counter and of trig_num
- clk  in  1  system clock (100 MHz domain)
- rst_n  in  1  asynchronous reset, active low
- SS_n  in  1  SPI slave select, asynchronous to clk
- SCLK  in  1  SPI clock, asynchronous to clk
- MOSI  in  1  SPI data, asynchronous to clk
- arm  in  1  enable; when low, no trigger is raised and the match counter is held at 0
- pos_edge  in  1  1 = sample MOSI on SCLK rise, 0 = sample on SCLK fall
- frm_len  in  $clog2(DATA_W+1)  expected bits per frame; legal range 1..DATA_W, 0 is treated as DATA_W
- match  in  DATA_W  compare pattern, right-aligned (last bit received sits at bit 0)
- mask  in  DATA_W  1 = don't-care bit
- trig_num  in  CNT_W  number of matching frames required per trigger; 0 is treated as 1
- trig  out  1  one-clk trigger pulse
- frm_done  out  1  one-clk pulse at every frame end
- frm_err  out  1  valid with frm_done; 1 = received bit count ≠ frm_len
- rx_data  out  DATA_W  last completed frame, right-aligned, zero-extended above the received bits

## Operation
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, then a third flop for edge detection.
  - Reset values: SS_n chain 1, SCLK chain 1, MOSI chain 0.
- FSM states:
  - IDLE → SHIFT on a falling edge of synchronised SS_n. On entry, the shift register and bit_cnt clear.
  - SHIFT: on the selected synchronised SCLK edge, shift left, bringing MOSI (synchronised value at that edge) into bit 0. bit_cnt increments and saturates at DATA_W+1.
  - SHIFT → IDLE on a rising edge of synchronised SS_n (frame end).
- SCLK edges while in IDLE are ignored.
- Frame end evaluation:
  - len = frm_len, with 0 mapped to DATA_W.
  - lmask = bits [len-1:0] set.
  - frm_err = (bit_cnt ≠ len).
  - hit = !frm_err && ((shift ^ match) & ~mask & lmask) == 0.
  - rx_data ← shift & lmask.
- Counting:
  - On hit with arm=1, match_cnt increments.
  - If the new count equals the effective trig_num, trig pulses and match_cnt returns to 0.
  - Non-matching frames and error frames do not change match_cnt.
  - arm=0 forces match_cnt=0 and trig=0.
- Configuration inputs (pos_edge, frm_len, match, mask, trig_num) are sampled only at the relevant event. They must be held stable while SS_n is low.
- Reset values: FSM IDLE, shift 0, bit_cnt 0, match_cnt 0, trig 0, frm_done 0, frm_err 0, rx_data 0.

## Timing
- Pin-to-detect latency: a pin transition produces its edge-detect strobe on the 3rd clk rising edge after the transition.
- Frame-end outputs:
  - trig, frm_done, frm_err and rx_data update on the clk edge following the SS_n rise strobe. That is 4 clks after the SS_n pin rise.
  - trig and frm_done are high for exactly one clk.
- Input constraints:
  - SCLK high and low phases must each be ≥4 clk.
  - The last selected SCLK edge must come ≥4 clk before the SS_n rise.
  - SS_n high time between frames must be ≥4 clk.
  - Violations produce undefined data but never lock up the FSM.
- Simultaneous events:
  - An SS_n rise strobe and an SCLK strobe in the same clk: the frame ends and the SCLK strobe is discarded.
  - An SS_n fall strobe in the same clk as an SCLK strobe: the SCLK strobe is ignored.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost; the next SS_n fall starts a clean frame.
- arm deasserted mid-frame: the frame still completes and sets frm_done/rx_data, but cannot trigger.
- Over-length frame (bit_cnt saturated): frm_err=1, no trigger, no counter wrap.

## Test plan
- DATA_W=16, frm_len=8, pos_edge=0, match=0x0066, mask=0, trig_num=1, arm=1, send 8-bit 0x66 → one trig pulse 4 clk after SS_n rise; frm_done=1, frm_err=0, rx_data=0x0066.
- Same configuration, send 0x67 → frm_done only, no trig. Set mask=0x0001 and resend 0x67 → trig.
- frm_len=16, pos_edge=1, match=0xA5C3, send 0xA5C3 on rising edges → trig, rx_data=0xA5C3. Switch to pos_edge=0 with a source that changes MOSI on SCLK fall → no trig.
- trig_num=3, send matching 0x66 three times → trig only on the 3rd. Send 2 more, drop arm for 1 clk, send 1 more → no trig.
- frm_len=8, send 7-bit and 9-bit frames whose trailing bits equal 0x66 → frm_done with frm_err=1 each time, no trig, match_cnt unchanged.
- Assert rst_n low after 4 bits of a frame → all outputs 0 within the same cycle. Release reset, send a full 0x66 frame → normal trig.

Source files
------------

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: resynchronises SS_n/SCLK/MOSI, rebuilds each frame and
// pulses trig when the Nth frame matching the masked pattern completes.
module spi_prot_trig #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          SS_n,
  input  logic                          SCLK,
  input  logic                          MOSI,
  input  logic                          arm,
  input  logic                          pos_edge,
  input  logic [$clog2(DATA_W+1)-1:0]   frm_len,
  input  logic [DATA_W-1:0]             match,
  input  logic [DATA_W-1:0]             mask,
  input  logic [CNT_W-1:0]              trig_num,
  output logic                          trig,
  output logic                          frm_done,
  output logic                          frm_err,
  output logic [DATA_W-1:0]             rx_data
);

  localparam int unsigned LEN_W = $clog2(DATA_W + 1);
  localparam int unsigned BC_W  = $clog2(DATA_W + 2);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [2:0]         r_ss_s;
  logic [2:0]         r_sclk_s;
  logic [2:0]         r_mosi_s;
  logic [DATA_W-1:0]  r_shift;
  logic [BC_W-1:0]    r_bit_cnt;
  logic               r_end;
  logic [CNT_W-1:0]   r_match_cnt;

  logic               w_ss_fall;
  logic               w_ss_rise;
  logic               w_sclk_edge;
  logic               w_mosi;
  logic [LEN_W-1:0]   w_len;
  logic [DATA_W-1:0]  w_lmask;
  logic               w_err;
  logic               w_hit;
  logic [CNT_W-1:0]   w_tn;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Two-flop synchronisers plus a third stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s   <= 3'b111;
      r_sclk_s <= 3'b111;
      r_mosi_s <= 3'b000;
    end else begin
      r_ss_s   <= {r_ss_s[1:0], SS_n};
      r_sclk_s <= {r_sclk_s[1:0], SCLK};
      r_mosi_s <= {r_mosi_s[1:0], MOSI};
    end
  end

  assign w_ss_fall   = r_ss_s[2] & ~r_ss_s[1];
  assign w_ss_rise   = ~r_ss_s[2] & r_ss_s[1];
  assign w_sclk_edge = pos_edge ? (~r_sclk_s[2] & r_sclk_s[1])
                                : (r_sclk_s[2] & ~r_sclk_s[1]);
  assign w_mosi      = r_mosi_s[1];

  // Frame reassembly; r_end flags the frame-end evaluation one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_end     <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state   <= ST_SHIFT;
            r_shift   <= '0;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_end   <= 1'b1;
          end else if (w_sclk_edge) begin
            r_shift <= {r_shift[DATA_W-2:0], w_mosi};
            if (r_bit_cnt != BC_W'(DATA_W + 1)) begin
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame-end evaluation against the live configuration
  always_comb begin
    w_len = (frm_len == '0) ? LEN_W'(DATA_W) : frm_len;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_lmask[i] = (i < 32'(w_len));
    end
    w_err     = (r_bit_cnt != BC_W'(w_len));
    w_hit     = !w_err && (((r_shift ^ match) & ~mask & w_lmask) == '0);
    w_tn      = (trig_num == '0) ? CNT_W'(1) : trig_num;
    w_cnt_inc = r_match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig        <= 1'b0;
      frm_done    <= 1'b0;
      frm_err     <= 1'b0;
      rx_data     <= '0;
      r_match_cnt <= '0;
    end else begin
      trig     <= 1'b0;
      frm_done <= 1'b0;
      if (r_end) begin
        frm_done <= 1'b1;
        frm_err  <= w_err;
        rx_data  <= r_shift & w_lmask;
      end
      if (!arm) begin
        r_match_cnt <= '0;
      end else if (r_end && w_hit) begin
        if (w_cnt_inc == w_tn) begin
          trig        <= 1'b1;
          r_match_cnt <= '0;
        end else begin
          r_match_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_prot_trig.sv
// Bench for spi_prot_trig: directed and random SPI frames scored against a
// frame-level arithmetic model of match/mask/length/Nth-trigger behaviour.
module tb_spi_prot_trig;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ss_n, sclk, mosi, arm, pos_edge;
  logic [LW-1:0] frm_len;
  logic [DW-1:0] match, mask, rx_data;
  logic [CW-1:0] trig_num;
  logic          trig, frm_done, frm_err;

  int n_chk = 0;
  int n_err = 0;
  int mcnt  = 0;

  spi_prot_trig #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
    .arm(arm), .pos_edge(pos_edge), .frm_len(frm_len), .match(match),
    .mask(mask), .trig_num(trig_num), .trig(trig), .frm_done(frm_done),
    .frm_err(frm_err), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, MSB first; bad=1 models a source that updates MOSI on the
  // sampling (falling) edge, so each sample sees the following bit.
  task automatic send_frame(input logic [31:0] bits, input int n, input bit bad, input string tag);
    logic [31:0] samp, shv, lm;
    int          len, cnt, tn;
    bit          err, hit, etrig;
    @(negedge clk);
    sclk = (bad || pos_edge) ? 1'b0 : 1'b1;
    wait_clks(6);
    ss_n = 1'b0;
    wait_clks(6);
    if (bad) begin
      mosi = bits[n-1];
      for (int i = n - 1; i >= 0; i--) begin
        wait_clks(6);
        sclk = 1'b1;
        wait_clks(6);
        sclk = 1'b0;
        mosi = (i > 0) ? bits[i-1] : 1'b0;
      end
    end else begin
      for (int i = n - 1; i >= 0; i--) begin
        mosi = bits[i];
        wait_clks(6);
        sclk = ~sclk;
        wait_clks(6);
        sclk = ~sclk;
      end
    end
    wait_clks(6);
    ss_n = 1'b1;

    samp  = bad ? ((bits << 1) & ((32'd1 << n) - 32'd1)) : bits;
    shv   = samp & ((32'd1 << DW) - 32'd1);
    cnt   = (n > int'(DW)) ? int'(DW) + 1 : n;
    len   = (frm_len == '0) ? int'(DW) : int'(frm_len);
    lm    = (32'd1 << len) - 32'd1;
    err   = (cnt != len);
    hit   = !err && (((shv ^ 32'(match)) & ~32'(mask) & lm) == 32'd0);
    etrig = 1'b0;
    if (!arm) begin
      mcnt = 0;
    end else if (hit) begin
      tn   = (trig_num == '0) ? 1 : int'(trig_num);
      mcnt = (mcnt + 1) % (1 << CW);
      if (mcnt == tn) begin
        etrig = 1'b1;
        mcnt  = 0;
      end
    end

    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        check({tag, ".trig"}, 32'(trig), 32'(etrig));
        check({tag, ".done"}, 32'(frm_done), 32'd1);
        check({tag, ".err"},  32'(frm_err), 32'(err));
        check({tag, ".rx"},   32'(rx_data), shv & lm);
      end else if (k == 3 || k == 5) begin
        check({tag, ".done_idle"}, 32'(frm_done), 32'd0);
        check({tag, ".trig_idle"}, 32'(trig), 32'd0);
      end
    end
  endtask

  task automatic cfg(input int len, input bit pe, input logic [DW-1:0] m,
                     input logic [DW-1:0] mk, input int tn);
    @(negedge clk);
    frm_len  = LW'(len);
    pos_edge = pe;
    match    = m;
    mask     = mk;
    trig_num = CW'(tn);
  endtask

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0; arm = 1'b1;
    pos_edge = 1'b0; frm_len = '0; match = '0; mask = '0; trig_num = '0;
    wait_clks(3);
    #1;
    check("rst.trig", 32'(trig), 32'd0);
    check("rst.done", 32'(frm_done), 32'd0);
    check("rst.err",  32'(frm_err), 32'd0);
    check("rst.rx",   32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(4);

    cfg(8, 1'b0, 16'h0066, 16'h0000, 1);
    send_frame(32'h66, 8, 1'b0, "d66");
    send_frame(32'h67, 8, 1'b0, "d67");
    cfg(8, 1'b0, 16'h0066, 16'h0001, 1);
    send_frame(32'h67, 8, 1'b0, "d67m");

    cfg(16, 1'b1, 16'hA5C3, 16'h0000, 1);
    send_frame(32'hA5C3, 16, 1'b0, "dA5C3");
    cfg(0, 1'b1, 16'hA5C3, 16'h0000, 1);
    send_frame(32'hA5C3, 16, 1'b0, "dlen0");
    cfg(16, 1'b0, 16'hA5C3, 16'h0000, 1);
    send_frame(32'hA5C3, 16, 1'b1, "dbadedge");

    cfg(8, 1'b0, 16'h0066, 16'h0000, 3);
    for (int i = 0; i < 3; i++) send_frame(32'h66, 8, 1'b0, "dn3");
    send_frame(32'h66, 8, 1'b0, "dn3b");
    send_frame(32'h66, 8, 1'b0, "dn3b");
    @(negedge clk); arm = 1'b0; mcnt = 0;
    @(negedge clk); arm = 1'b1;
    send_frame(32'h66, 8, 1'b0, "dn3arm");

    cfg(8, 1'b0, 16'h0066, 16'h0000, 2);
    send_frame(32'h66,  8, 1'b0, "derr0");
    send_frame(32'h66,  7, 1'b0, "derr7");
    send_frame(32'h166, 9, 1'b0, "derr9");
    send_frame(32'h3FF66, 18, 1'b0, "derr18");
    send_frame(32'h66,  8, 1'b0, "derr1");

    // Reset in the middle of a frame, after four bits
    cfg(8, 1'b0, 16'h0066, 16'h0000, 1);
    @(negedge clk); sclk = 1'b1; wait_clks(6); ss_n = 1'b0; wait_clks(6);
    for (int i = 7; i >= 4; i--) begin
      mosi = (i == 6 || i == 5) ? 1'b1 : 1'b0;
      wait_clks(6); sclk = 1'b0; wait_clks(6); sclk = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.trig", 32'(trig), 32'd0);
    check("mid_rst.done", 32'(frm_done), 32'd0);
    check("mid_rst.err",  32'(frm_err), 32'd0);
    check("mid_rst.rx",   32'(rx_data), 32'd0);
    ss_n = 1'b1; sclk = 1'b1; mcnt = 0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(6);
    send_frame(32'h66, 8, 1'b0, "post_rst");

    for (int f = 0; f < 40; f++) begin
      int          lcfg, len, n, sel;
      logic [31:0] bits;
      logic [DW-1:0] m, mk;
      lcfg = $urandom_range(0, DW);
      len  = (lcfg == 0) ? int'(DW) : lcfg;
      sel  = $urandom_range(0, 9);
      n    = (sel == 0) ? len - 1 : (sel == 1) ? len + 1 :
             (sel == 2) ? int'($urandom_range(DW + 1, DW + 2)) : len;
      bits = $urandom & ((32'd1 << n) - 32'd1);
      m    = ($urandom_range(0, 1) == 1) ? DW'(bits) : DW'($urandom);
      mk   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
      cfg(lcfg, 1'($urandom_range(0, 1)), m, mk, $urandom_range(0, 3));
      arm = ($urandom_range(0, 9) != 0);
      send_frame(bits, n, 1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
